// File: rtl/gpr_write_arbiter.sv
// Shares the GPR write port: writeback wins combinationally (0 added latency), a losing LU result parks
// in a 1-entry buffer (o_luReady low while held); after STARVE_LIMIT lost cycles o_wbStall drains it. Option: GPR_ARB_BYPASS_EN.
module gpr_write_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_wbValid,
   input  logic                  i_wbRegWrEnable,
   input  logic [ADDR_WIDTH-1:0] i_wbRegWrAddr,
   input  logic [DATA_WIDTH-1:0] i_wbRegWrData,
   output logic                  o_wbStall,
   input  logic                  i_luValid,
   output logic                  o_luReady,
   input  logic [ADDR_WIDTH-1:0] i_luRegWrAddr,
   input  logic [DATA_WIDTH-1:0] i_luRegWrData,
`ifdef GPR_ARB_BYPASS_EN
   output logic                  o_pendValid,
   output logic [ADDR_WIDTH-1:0] o_pendAddr,
   output logic [DATA_WIDTH-1:0] o_pendData,
`endif
   output logic                  o_regWrEnable,
   output logic [ADDR_WIDTH-1:0] o_regWrAddr,
   output logic [DATA_WIDTH-1:0] o_regWrData
);

   typedef enum logic [1:0] {IDLE, PENDING, DRAIN} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t                state, nextState;
   logic [3:0]            cnt, nextCnt;
   logic [ADDR_WIDTH-1:0] bufAddr;
   logic [DATA_WIDTH-1:0] bufData;
   logic                  capture;
   logic                  wbActive;
   logic                  luLive;

   assign wbActive = i_wbValid & i_wbRegWrEnable & (i_wbRegWrAddr != '0);
   // Results to x0 are acknowledged but never reach the port or the buffer.
   assign luLive   = i_luValid & (i_luRegWrAddr != '0);

   always_comb begin
      nextState     = state;
      nextCnt       = cnt;
      capture       = 1'b0;
      o_luReady     = 1'b0;
      o_wbStall     = 1'b0;
      o_regWrEnable = 1'b0;
      o_regWrAddr   = '0;
      o_regWrData   = '0;

      case (state)
         IDLE: begin
            o_luReady = 1'b1;
            if (wbActive) begin
               o_regWrEnable = 1'b1;
               o_regWrAddr   = i_wbRegWrAddr;
               o_regWrData   = i_wbRegWrData;
               if (luLive) begin
                  capture   = 1'b1;
                  nextCnt   = 4'd1;
                  nextState = (STARVE_LIMIT == 1) ? DRAIN : PENDING;
               end
            end else if (luLive) begin
               o_regWrEnable = 1'b1;
               o_regWrAddr   = i_luRegWrAddr;
               o_regWrData   = i_luRegWrData;
            end
         end
         PENDING: begin
            o_regWrEnable = 1'b1;
            if (!wbActive) begin
               o_regWrAddr = bufAddr;
               o_regWrData = bufData;
               nextCnt     = 4'd0;
               nextState   = IDLE;
            end else begin
               o_regWrAddr = i_wbRegWrAddr;
               o_regWrData = i_wbRegWrData;
               nextCnt     = cnt + 4'd1;
               nextState   = (cnt + 4'd1 == LIMIT) ? DRAIN : PENDING;
            end
         end
         DRAIN: begin
            // The stall freezes MEM/WB, so the suppressed writeback retries next cycle.
            o_wbStall     = 1'b1;
            o_regWrEnable = 1'b1;
            o_regWrAddr   = bufAddr;
            o_regWrData   = bufData;
            nextCnt       = 4'd0;
            nextState     = IDLE;
         end
         default: nextState = IDLE;
      endcase

      if (i_reset) begin
         nextState     = IDLE;
         nextCnt       = 4'd0;
         capture       = 1'b0;
         o_luReady     = 1'b0;
         o_wbStall     = 1'b0;
         o_regWrEnable = 1'b0;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         bufAddr <= '0;
         bufData <= '0;
      end else begin
         state <= nextState;
         cnt   <= nextCnt;
         if (capture) begin
            bufAddr <= i_luRegWrAddr;
            bufData <= i_luRegWrData;
         end
      end
   end

`ifdef GPR_ARB_BYPASS_EN
   assign o_pendValid = (state != IDLE) & ~i_reset;
   assign o_pendAddr  = bufAddr;
   assign o_pendData  = bufData;
`endif

endmodule

// File: doc/gpr_write_arbiter.md
Name: gpr_write_arbiter

Overview:
Shares the single GPR register-file write port between the in-order writeback stage (MEM/WB outputs) and the long-latency unit (divider/late loads), which returns results out of band. Writeback always has priority. A losing long-latency result is parked in a 1-entry hold buffer. After a bounded number of lost cycles, the block stalls the pipeline for one cycle to drain the buffer. It sits between the MEM/WB pipeline register, the long-latency unit and the register file.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, width of GPR address
STARVE_LIMIT, 4, lost arbitration cycles (including the capture cycle) before a forced drain; legal range 1..15

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_wbValid  in  1  writeback-stage operation valid
i_wbRegWrEnable  in  1  writeback-stage write request
i_wbRegWrAddr  in  ADDR_WIDTH  writeback destination register
i_wbRegWrData  in  DATA_WIDTH  writeback data
o_wbStall  out  1  holds MEM/WB and all upstream stages for this cycle
i_luValid  in  1  long-latency result valid
o_luReady  out  1  arbiter accepts the long-latency result
i_luRegWrAddr  in  ADDR_WIDTH  long-latency destination register
i_luRegWrData  in  DATA_WIDTH  long-latency data
o_regWrEnable  out  1  register-file write strobe
o_regWrAddr  out  ADDR_WIDTH  register-file write address
o_regWrData  out  DATA_WIDTH  register-file write data

Behaviour:
- wbActive = i_wbValid & i_wbRegWrEnable & (i_wbRegWrAddr != 0). A writeback targeting x0 leaves the port free.
- Long-latency handshake completes on i_luValid & o_luReady. A result with addr 0 is accepted and discarded, and is never buffered.
- Write-port outputs are combinational from current state and inputs. There is no added latency on the writeback path.
- FSM states: IDLE, PENDING, DRAIN. Other state: hold buffer (addr, data) and counter cnt of width 4.
- IDLE:
  - o_luReady=1, o_wbStall=0.
  - If wbActive: port carries the writeback write.
  - Else if i_luValid: port carries the long-latency write directly (pass-through); stay IDLE.
  - If wbActive & i_luValid (lu addr != 0): capture into buffer, cnt<=1. Next state is DRAIN if STARVE_LIMIT==1, else PENDING.
- PENDING:
  - o_luReady=0, o_wbStall=0.
  - If !wbActive: port writes the buffer; next state IDLE.
  - Else: port carries the writeback write; cnt<=cnt+1; next state is DRAIN if cnt+1==STARVE_LIMIT, else PENDING.
- DRAIN:
  - o_luReady=0, o_wbStall=1.
  - Port writes the buffer. The writeback write is suppressed this cycle and is held by the stall, so it retries next cycle.
  - Next state IDLE.
- o_regWrEnable=0 whenever no source is granted.
- Write ordering between the two sources to the same register is not checked here. The hazard scoreboard guarantees no overlapping destinations.
- Reset (synchronous, any state, including mid-PENDING/DRAIN):
  - next state IDLE, cnt<=0, buffer invalidated (content dropped).
  - While i_reset=1: o_regWrEnable=0, o_wbStall=0, o_luReady=0.
  - First cycle after reset: o_luReady=1, o_wbStall=0, o_regWrEnable follows inputs.
- Pipeline flush does not affect this block. Buffered results are architecturally committed and are always written.

Optional Feature:
GPR_ARB_BYPASS_EN:
- When defined, adds ports o_pendValid (1), o_pendAddr (ADDR_WIDTH) and o_pendData (DATA_WIDTH).
- These expose the hold buffer to decode-stage forwarding. o_pendValid=1 in PENDING and DRAIN, else 0, and is 0 during reset.
- When not defined, these ports do not exist and no forwarding logic is generated.

Test Plan:
1. Reset held 2 cycles, then released with no requests -> o_regWrEnable=0, o_wbStall=0; o_luReady=0 during reset, 1 in the first cycle after.
2. wbActive with addr 5, data 0xAAAA0001, and no LU request -> same-cycle write addr 5, data 0xAAAA0001, o_luReady=1; then LU alone with addr 7, data 0x1234 -> pass-through write of addr 7 in the same cycle.
3. LU addr 9 / 0xDEAD arrives together with a wb write to addr 3, then wb goes idle next cycle -> cycle0 writes addr 3, cycle1 writes 9/0xDEAD, cycle2 o_luReady=1; o_wbStall never asserted.
4. STARVE_LIMIT=4, wb writes every cycle, LU addr 11 arrives at cycle0 -> cycles0-3 wb wins; cycle4 o_wbStall=1 and addr 11 written; cycle5 the stalled wb write is performed and o_luReady=1.
5. wb write to x0 together with LU addr 4 -> LU written directly, nothing buffered; LU addr 0 with no wb -> o_regWrEnable=0 and handshake completes.
6. i_reset asserted while in PENDING holding addr 12 -> addr 12 is never written, state IDLE after reset; with GPR_ARB_BYPASS_EN, o_pendValid=1 before reset and 0 after.
